// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Digit-serial adder/subtractor. An operation is captured on start, then one
// DIGIT-bit slice is added per clock (least-significant slice first) with the
// carry kept in a register between slices. After STEPS = WIDTH/DIGIT slices
// the result, carry-out and signed overflow are loaded together and done
// pulses for one cycle. WIDTH must be an integer multiple of DIGIT.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset, wins over start
//   start      in   begin a new operation (honoured in IDLE or DONE only)
//   sub        in   0 = a + b + cin, 1 = a - b (a + ~b + 1, cin ignored)
//   a, b       in   WIDTH-bit operands, captured with start
//   cin        in   carry-in for add, captured with start
//   busy       out  high in every slice-processing (RUN) cycle
//   done       out  one-cycle pulse when sum/cout/ovf have just been loaded
//   sum        out  registered WIDTH-bit result, held until the next done
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  two's complement overflow
//   dbg_state  out  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Handshake: start is a level sampled on each rising edge; it is accepted
// only when busy is low. A request made while busy is high is dropped, not
// queued. Results are valid in the cycle done is high and stay valid until
// the next done, so a consumer may read them any time after that pulse.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int STEPS = WIDTH / DIGIT;
    // Keep the counter at least one bit wide so STEPS == 1 still elaborates.
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] op_a_q,  op_a_d;
    logic [WIDTH-1:0] op_b_q,  op_b_d;   // already inverted for subtract
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] acc_q,   acc_d;    // partial result, filled slice by slice
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    logic [31:0]      base;
    logic [DIGIT:0]   slice_sum;
    logic [WIDTH-1:0] acc_merged;

    // Current slice: DIGIT-bit add with the carry register as carry-in.
    // acc_merged is the partial result with this slice written in, so the
    // final slice can be loaded into sum on the same edge that enters DONE.
    always_comb begin
        base       = 32'(cnt_q) * 32'(DIGIT);
        slice_sum  = {1'b0, op_a_q[base +: DIGIT]}
                   + {1'b0, op_b_q[base +: DIGIT]}
                   + {{DIGIT{1'b0}}, carry_q};
        acc_merged = acc_q;
        acc_merged[base +: DIGIT] = slice_sum[DIGIT-1:0];
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtract is a + ~b + 1: invert b once at capture and
                    // seed the carry with 1, so RUN never looks at the mode.
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                acc_d   = acc_merged;
                carry_d = slice_sum[DIGIT];
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                    sum_d   = acc_merged;
                    cout_d  = slice_sum[DIGIT];
                    // Same-sign operands producing a different-sign result.
                    ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                              (acc_merged[WIDTH-1] != op_a_q[WIDTH-1]);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder. u_dut is the default 16/4 configuration;
// u_dut1 is 16/16 (single slice). Both share operands and reset, each has
// its own start. Inputs change on the falling edge, outputs are read on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        start1;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;

    logic        busy,  done,  cout,  ovf;
    logic [15:0] sum;
    logic [1:0]  dbg_state;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] sum1;
    logic [1:0]  dbg_state1;

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout),
        .ovf(ovf), .dbg_state(dbg_state)
    );

    serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .ovf(ovf1), .dbg_state(dbg_state1)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] exp_q[$];   // {cout, ovf, sum}

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present an operation with start for exactly one rising edge. Returns
    // at the falling edge of the first RUN cycle.
    task automatic drive_start(input logic s, input logic [15:0] av,
                               input logic [15:0] bv, input logic ci);
        @(negedge clk);
        sub = s; a = av; b = bv; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done on u_dut, counting cycles and busy cycles.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string tag);
        logic [17:0] e;
        e = exp_q.pop_front();
        check({tag, "_sum"},  32'(sum),  32'(e[15:0]));
        check({tag, "_cout"}, 32'(cout), 32'(e[17]));
        check({tag, "_ovf"},  32'(ovf),  32'(e[16]));
    endtask

    // Full operation on u_dut: latency, busy width, results, one-cycle done.
    task automatic run_op(input string tag, input logic s,
                          input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic [17:0] exp);
        int cyc, bc;
        exp_q.push_back(exp);
        drive_start(s, av, bv, ci);
        wait_done(cyc, bc);
        check({tag, "_lat"},  32'(cyc), 32'd4);
        check({tag, "_busy"}, 32'(bc),  32'd4);
        check_result(tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, bc, n_done, gap;
        logic [15:0] got;

        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_sum",   32'(sum),       32'd0);
        check("rst_cout",  32'(cout),      32'd0);
        check("rst_ovf",   32'(ovf),       32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_sum1",  32'(sum1),      32'd0);
        rst = 1'b0;

        // Arithmetic vectors, expected {cout, ovf, sum}
        run_op("add_wrap",  1'b0, 16'h0001, 16'hFFFF, 1'b0, {1'b1, 1'b0, 16'h0000});
        run_op("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h8000});
        run_op("add_cin",   1'b0, 16'h1234, 16'h1111, 1'b1, {1'b0, 1'b0, 16'h2346});
        run_op("sub_neg",   1'b1, 16'h0005, 16'h0007, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        run_op("sub_ovf",   1'b1, 16'h8000, 16'h0001, 1'b0, {1'b1, 1'b1, 16'h7FFF});

        // start re-asserted during RUN with other operands must be dropped
        exp_q.push_back({1'b0, 1'b0, 16'h0003});
        drive_start(1'b0, 16'h0001, 16'h0002, 1'b0);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        got = '0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                n_done++;
                got = sum;
            end
            @(negedge clk);
        end
        check("ignore_ndone", 32'(n_done), 32'd1);
        check("ignore_got",   32'(got),    32'h0003);
        check_result("ignore_hold");   // still held after returning to IDLE

        // start held through DONE: second operation with no idle cycle
        exp_q.push_back({1'b0, 1'b0, 16'h0030});
        exp_q.push_back({1'b0, 1'b0, 16'h3000});
        @(negedge clk);
        sub = 1'b0; cin = 1'b0; a = 16'h0010; b = 16'h0020; start = 1'b1;
        @(negedge clk);
        a = 16'h1000; b = 16'h2000;    // captured at the DONE edge
        wait_done(cyc, bc);
        check("b2b_lat1", 32'(cyc), 32'd4);
        check_result("b2b_first");
        @(negedge clk);
        start = 1'b0;
        gap = 1;
        check("b2b_busy",     32'(busy), 32'd1);
        check("b2b_prior",    32'(sum),  32'h0030);
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_gap", 32'(gap), 32'd5);
        check_result("b2b_second");
        @(negedge clk);

        // reset in the second RUN cycle aborts the operation
        drive_start(1'b0, 16'h00AA, 16'h0011, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",  32'(busy),      32'd0);
        check("abort_done",  32'(done),      32'd0);
        check("abort_sum",   32'(sum),       32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort_nodone", 32'(n_done), 32'd0);

        // reset wins over start in the same cycle
        a = 16'h0F0F; b = 16'h0101; rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("prio_busy",  32'(busy),      32'd0);
        check("prio_state", 32'(dbg_state), 32'd0);

        run_op("after_abort", 1'b0, 16'h00FF, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0100});

        // single-slice configuration
        @(negedge clk);
        sub = 1'b0; cin = 1'b0; a = 16'hFFFF; b = 16'h0001; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("d16_busy", 32'(busy1), 32'd1);
        cyc = 0;
        while (!done1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("d16_lat",  32'(cyc),   32'd1);
        check("d16_sum",  32'(sum1),  32'h0000);
        check("d16_cout", 32'(cout1), 32'd1);
        check("d16_ovf",  32'(ovf1),  32'd0);
        @(negedge clk);
        check("d16_pulse", 32'(dbg_state1), 32'd0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
